// File: rtl/exec_wb_unit.sv
// Execute/write-back unit: single-cycle ALU ops plus a load/store engine with an ack timeout.
// Optional multiplier compiled in with `define EXEC_WB_MUL_EN; without it opcode 4 is illegal.
module exec_wb_unit #(
  parameter int DW  = 16,
  parameter int RW  = 4,
  parameter int AW  = 8,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    opcode,
  input  logic [RW-1:0] dest_reg,
  input  logic [DW-1:0] src1,
  input  logic [DW-1:0] src2,
  input  logic          fwd1,
  input  logic          fwd2,
  input  logic [AW-1:0] mem_addr,
  output logic          wb_valid,
  output logic [RW-1:0] wb_reg,
  output logic [DW-1:0] wb_data,
  output logic          mem_rd_req,
  output logic          mem_wr_req,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] psw,
  output logic          halt,
  output logic          illegal
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, HALTED} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t        state;
  logic [DW-1:0] last_result;
  logic [DW-1:0] rd_cap;
  logic          rd_done;
  logic [7:0]    tmo_cnt;

  logic [DW-1:0] a, b, res;
  logic          res_c, res_v, is_alu, bad_op;
  logic [DW:0]   sum, diff, shl;
`ifdef EXEC_WB_MUL_EN
  logic [2*DW-1:0] prod;
`endif

  assign in_ready = (state == IDLE);

  // Status word: carry, overflow, zero, negative, sticky bus error, then zeros.
  function automatic logic [DW-1:0] mk_psw(input logic [DW-1:0] r, input logic c,
                                           input logic v, input logic be);
    return {c, v, (r == '0), r[DW-1], be, {(DW-5){1'b0}}};
  endfunction

  always_comb begin
    a      = fwd1 ? last_result : src1;
    b      = fwd2 ? last_result : src2;
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    shl    = {1'b0, a} << b;
`ifdef EXEC_WB_MUL_EN
    prod   = a * b;
`endif
    res    = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    is_alu = 1'b1;
    bad_op = 1'b0;
    case (opcode)
      4'd2: begin
        res   = sum[DW-1:0];
        res_c = sum[DW];
        res_v = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      4'd3: begin
        res   = diff[DW-1:0];
        res_c = diff[DW];
        res_v = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      end
`ifdef EXEC_WB_MUL_EN
      4'd4: begin
        res   = prod[DW-1:0];
        res_c = |prod[2*DW-1:DW];
      end
`endif
      // Bit DW of the widened shift is the last bit pushed out; zero once b > DW.
      4'd5: begin
        res   = shl[DW-1:0];
        res_c = shl[DW];
      end
      4'd6:  res = a >> b;
      4'd7:  res = a & b;
      4'd8:  res = a | b;
      4'd9:  res = ~a;
      4'd10: res = a ^ b;
      4'd0, 4'd1, 4'd14, 4'd15: is_alu = 1'b0;
      default: begin
        is_alu = 1'b0;
        bad_op = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wb_valid    <= 1'b0;
      wb_reg      <= '0;
      wb_data     <= '0;
      mem_rd_req  <= 1'b0;
      mem_wr_req  <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata   <= '0;
      psw         <= '0;
      halt        <= 1'b0;
      illegal     <= 1'b0;
      last_result <= '0;
      rd_cap      <= '0;
      rd_done     <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (bad_op) begin
              state   <= HALTED;
              halt    <= 1'b1;
              illegal <= 1'b1;
            end else if (opcode == 4'd1) begin
              state <= HALTED;
              halt  <= 1'b1;
            end else if (opcode == 4'd14) begin
              state      <= RD_WAIT;
              mem_rd_req <= 1'b1;
              mem_addr_o <= mem_addr;
              wb_reg     <= dest_reg;
              rd_done    <= 1'b0;
              tmo_cnt    <= '0;
            end else if (opcode == 4'd15) begin
              state      <= WR_WAIT;
              mem_wr_req <= 1'b1;
              mem_addr_o <= mem_addr;
              mem_wdata  <= a;
              tmo_cnt    <= '0;
            end else if (is_alu) begin
              wb_valid    <= 1'b1;
              wb_reg      <= dest_reg;
              wb_data     <= res;
              last_result <= res;
              psw         <= mk_psw(res, res_c, res_v, psw[DW-5]);
            end
          end
        end
        RD_WAIT: begin
          if (rd_done) begin
            state       <= IDLE;
            wb_valid    <= 1'b1;
            wb_data     <= rd_cap;
            last_result <= rd_cap;
            psw         <= mk_psw(rd_cap, 1'b0, 1'b0, psw[DW-5]);
          end else if (mem_ack) begin
            rd_cap     <= mem_rdata;
            rd_done    <= 1'b1;
            mem_rd_req <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            state      <= IDLE;
            mem_rd_req <= 1'b0;
            psw[DW-5]  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        WR_WAIT: begin
          if (mem_ack) begin
            state      <= IDLE;
            mem_wr_req <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            state      <= IDLE;
            mem_wr_req <= 1'b0;
            psw[DW-5]  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: begin
          halt <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/exec_wb_unit.md
EXEC_WB_UNIT -- requirements
Module: exec_wb_unit

Interface
REQ-001 SHALL have parameter DW, 16, datapath and register-value width (8..32).
REQ-002 SHALL have parameter RW, 4, register-index width.
REQ-003 SHALL have parameter AW, 8, memory-address width.
REQ-004 SHALL have parameter TMO, 15, memory-ack timeout in cycles (1..255).
REQ-005 SHALL have ports, first clk and rst: reset rst, asynchronous, active-high; clock clk.
REQ-006 SHALL have ports, one per line:
  in_valid  in  1  issue stage presents an instruction
  in_ready  out  1  unit can accept this cycle
  opcode  in  4  operation code
  dest_reg  in  RW  destination register index
  src1, src2  in  DW  operand values from register file
  fwd1, fwd2  in  1  substitute last_result for src1/src2
  mem_addr  in  AW  load/store address
  wb_valid  out  1  one-cycle register-write strobe
  wb_reg  out  RW  register index written
  wb_data  out  DW  value written
  mem_rd_req, mem_wr_req  out  1  memory requests, held until ack or timeout
  mem_addr_o  out  AW  memory address
  mem_wdata  out  DW  store data
  mem_rdata  in  DW  load data, valid with mem_ack
  mem_ack  in  1  memory completion pulse
  psw  out  DW  status word
  halt  out  1  unit powered down
  illegal  out  1  sticky illegal-opcode flag

Function
REQ-007 SHALL accept an instruction when in_valid and in_ready are both 1 at a rising clk edge; in_ready SHALL be 1 only in state IDLE.
REQ-008 SHALL implement states IDLE, RD_WAIT, WR_WAIT, HALTED; LOAD moves IDLE->RD_WAIT, STORE moves IDLE->WR_WAIT, HLT or illegal opcode moves IDLE->HALTED; other ops stay in IDLE.
REQ-009 SHALL decode opcodes: 0 NOP, 1 HLT, 2 ADD, 3 SUB, 4 MUL, 5 SL, 6 SR, 7 AND, 8 OR, 9 NOT (src2 ignored), 10 XOR, 14 LOAD, 15 STORE; 11-13 are illegal.
REQ-010 SHALL select operand a = fwd1 ? last_result : src1, b = fwd2 ? last_result : src2, sampled at acceptance.
REQ-011 SHALL, for ALU ops 2-10, assert wb_valid for exactly one cycle on the edge after acceptance with wb_reg = dest_reg and wb_data = result mod 2^DW (latency 1), and load last_result on the same edge.
REQ-012 SHALL compute ADD/SUB on DW+1 bits with carry (borrow for SUB) into psw[DW-1]; signed overflow into psw[DW-2].
REQ-013 SHALL compute MUL low DW bits as result; psw[DW-1] = 1 when the upper DW product bits are nonzero.
REQ-014 SHALL shift by b; SL carry = last bit shifted out, shift amounts >= DW give result 0 (carry 0 if amount > DW); SR logical, carry 0.
REQ-015 SHALL, on every ALU op and completed LOAD, rewrite psw: zero flag psw[DW-3] = (result == 0), negative flag psw[DW-4] = result MSB; carry/overflow cleared for logic ops and LOAD; bits DW-6..0 always 0.
REQ-016 SHALL for LOAD drive mem_addr_o = mem_addr and mem_rd_req = 1 from the edge after acceptance until the edge sampling mem_ack; on that edge capture mem_rdata, and on the next edge pulse wb_valid with wb_data = captured value, update last_result and return to IDLE.
REQ-017 SHALL for STORE drive mem_addr_o, mem_wdata = a and mem_wr_req = 1 from the edge after acceptance until mem_ack; no wb_valid; return to IDLE on ack.
REQ-018 SHALL count wait cycles in RD_WAIT/WR_WAIT; if mem_ack is absent for TMO cycles, drop the request, set sticky bus-error psw[DW-5], issue no write-back, return to IDLE.
REQ-019 SHALL ignore mem_ack in IDLE and HALTED.
REQ-020 SHALL in HALTED hold halt = 1, in_ready = 0, all requests 0, until reset; illegal opcode also sets illegal = 1.
REQ-021 SHALL treat NOP as accepted with no state, psw or write-back change.

Reset
REQ-022 SHALL on rst asynchronously clear state to IDLE, wb_valid, mem_rd_req, mem_wr_req, halt, illegal, psw, last_result, wb_reg, wb_data, mem_addr_o, mem_wdata and the timeout counter to 0.
REQ-023 SHALL abort any pending memory request immediately on rst with no write-back; in_ready = 1 on the first edge after rst deasserts.

Configuration
REQ-024 SHALL compile MUL in when macro EXEC_WB_MUL_EN is defined; without it opcode 4 SHALL be illegal (REQ-020) and no multiplier logic SHALL exist.

Verification
REQ-025 ADD a=0x7FFF b=0x0001 dest 3 -> next cycle wb_valid, wb_reg 3, wb_data 0x8000, psw overflow=1, negative=1, carry=0, zero=0.
REQ-026 SUB a=5 then SUB with fwd1=1, src2=5 -> second result 0x0000, zero=1, carry=0; first result forwarded correctly.
REQ-027 LOAD addr 0x2A, mem_ack after 3 cycles with rdata 0x1234 -> mem_rd_req high 3 cycles, wb_data 0x1234 one cycle after ack, in_ready low throughout.
REQ-028 STORE addr 0x10, no ack, TMO=15 -> mem_wr_req high 15 cycles then 0, psw[DW-5]=1, in_ready returns 1, no wb_valid.
REQ-029 opcode 12, then rst mid-LOAD in a later run -> halt=1, illegal=1, in_ready=0; rst during RD_WAIT drops mem_rd_req same cycle, no write-back.
REQ-030 MUL 0x0100*0x0100 with EXEC_WB_MUL_EN -> wb_data 0x0000, carry=1, zero=1; without macro -> halt=1, illegal=1.
